// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcode constants, FSM state
// encoding, control-bundle type and the common config macros.
`ifndef HAZARD_CTRL_DEFS_SVH
`define HAZARD_CTRL_DEFS_SVH
`define XREG_ADDRWIDTH 5
`define TURE 1'b1
`define FALSE 1'b0
`define RST_ENABLE 1'b1
`endif

package hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_RSVD   = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic load_hazerd;
    logic flush_flag;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE  = '{default: `FALSE};
  localparam hz_ctrl_t CTRL_STALL = '{pc_stall: `TURE, if_id_stall: `TURE, if_id_flush: `FALSE,
                                      load_hazerd: `TURE, flush_flag: `FALSE};
  // The redirect target must fetch, so a flush never holds the PC or IF/ID.
  localparam hz_ctrl_t CTRL_FLUSH = '{pc_stall: `FALSE, if_id_stall: `FALSE, if_id_flush: `TURE,
                                      load_hazerd: `FALSE, flush_flag: `TURE};

  function automatic logic is_ctrl_xfer(input logic [6:0] opcode);
    return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running event counter: +1 per cycle with inc high, wraps modulo 2^W.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RST_ENABLE) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and taken-redirect flushes, sequenced by a
// RUN/LSTALL/FLUSH FSM with a down-counter. Define HAZARD_PERF_EN for stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`XREG_ADDRWIDTH-1:0] id_rs1_addr,
  input  logic [`XREG_ADDRWIDTH-1:0] id_rs2_addr,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [6:0]                 ex_opcode,
  input  logic                       ex_rd_en,
  input  logic [`XREG_ADDRWIDTH-1:0] ex_rd_addr,
  input  logic                       ex_redirect,
  output logic                       pc_stall,
  output logic                       if_id_stall,
  output logic                       if_id_flush,
  output logic                       load_hazerd,
  output logic                       flush_flag,
  output logic [1:0]                 state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]          stall_cnt,
  output logic [PERF_W-1:0]          flush_cnt
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15 || FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || PERF_W < 1)
  begin : g_cfg_err
    $error("hazard_ctrl: LOAD_LAT/FLUSH_CYCLES must be 1..15 and PERF_W >= 1");
  end

  localparam logic [3:0] LSTALL_RELOAD = 4'(LOAD_LAT - 1);
  localparam logic [3:0] FLUSH_RELOAD  = 4'(FLUSH_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  hz_ctrl_t   ctrl;
  logic       luse;

  assign luse = (ex_opcode == OPC_LOAD) && ex_rd_en && (ex_rd_addr != '0) &&
                ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                 (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = ST_RUN;
    cnt_d   = '0;
    ctrl    = CTRL_NONE;

    if (ex_redirect) begin
      // A redirect wins in every state; any pending stall is dropped.
      ctrl = CTRL_FLUSH;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end
    end else begin
      unique case (state_q)
        ST_LSTALL: begin
          // The load has already left EX, so the hold no longer depends on luse.
          ctrl = CTRL_STALL;
          if (cnt_q > 4'd1) begin
            state_d = ST_LSTALL;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        ST_FLUSH: begin
          ctrl = CTRL_FLUSH;
          if (cnt_q > 4'd1) begin
            state_d = ST_FLUSH;
            cnt_d   = cnt_q - 4'd1;
          end
        end
        ST_RUN: begin
          if (luse) begin
            ctrl = CTRL_STALL;
            if (LOAD_LAT > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = LSTALL_RELOAD;
            end
          end
        end
        default: begin
          // Unreachable encoding: behave as RUN for one cycle, then recover to RUN.
          if (luse) begin
            ctrl = CTRL_STALL;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RST_ENABLE) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: outputs are gated by rst directly so they drop the instant reset asserts.
  assign pc_stall    = rst ? `FALSE : ctrl.pc_stall;
  assign if_id_stall = rst ? `FALSE : ctrl.if_id_stall;
  assign if_id_flush = rst ? `FALSE : ctrl.if_id_flush;
  assign load_hazerd = rst ? `FALSE : ctrl.load_hazerd;
  assign flush_flag  = rst ? `FALSE : ctrl.flush_flag;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load_hazerd),
    .count (stall_cnt)
  );

  hazard_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_flag),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three parameterisations driven in parallel, expected
// responses from a remaining-cycles reference model, checked by an independent monitor.
module tb_hazard_ctrl;

  localparam int N = 3;
  localparam int LL[N] = '{1, 3, 4};
  localparam int FC[N] = '{1, 2, 3};
  localparam logic [6:0] LW = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_rd_en, ex_redirect;
  logic [6:0] ex_opcode;

  logic       pc_stall_w    [N];
  logic       if_id_stall_w [N];
  logic       if_id_flush_w [N];
  logic       load_hazerd_w [N];
  logic       flush_flag_w  [N];
  logic [1:0] state_w       [N];
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_w  [N];
  logic [31:0] flush_cnt_w  [N];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    hazard_ctrl #(.LOAD_LAT(LL[g]), .FLUSH_CYCLES(FC[g]), .PERF_W(32)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_opcode   (ex_opcode),
      .ex_rd_en    (ex_rd_en),
      .ex_rd_addr  (ex_rd_addr),
      .ex_redirect (ex_redirect),
      .pc_stall    (pc_stall_w[g]),
      .if_id_stall (if_id_stall_w[g]),
      .if_id_flush (if_id_flush_w[g]),
      .load_hazerd (load_hazerd_w[g]),
      .flush_flag  (flush_flag_w[g]),
      .state_o     (state_w[g])
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt   (stall_cnt_w[g]),
      .flush_cnt   (flush_cnt_w[g])
`endif
    );
  end

  typedef struct packed {
    int                    cyc;
    logic [N-1:0][4:0]     ctrl;   // {pc_stall, if_id_stall, if_id_flush, load_hazerd, flush_flag}
    logic [N-1:0][1:0]     st;
    logic [N-1:0][31:0]    sc;
    logic [N-1:0][31:0]    fc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          cyc_n = 0;
  int          stall_left[N];
  int          flush_left[N];
  logic [31:0] m_sc[N];
  logic [31:0] m_fc[N];

  task automatic check(input string name, input int inst, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc%0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model tracks how many stall/flush cycles are still owed.
  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [6:0] op,
                      input logic rden, input logic [4:0] rd, input logic redir);
    exp_t e;
    logic lu, lh, ff;
    logic [1:0] st;
    @(posedge clk);
    #1;
    rst = r; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_opcode = op; ex_rd_en = rden; ex_rd_addr = rd; ex_redirect = redir;
    lu = (op == LW) && rden && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e = '0;
    e.cyc = cyc_n;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      lh = 1'b0;
      ff = 1'b0;
      st = 2'd0;
      if (r) begin
        stall_left[i] = 0;
        flush_left[i] = 0;
        m_sc[i] = '0;
        m_fc[i] = '0;
      end else begin
        st = (flush_left[i] > 0) ? 2'd2 : (stall_left[i] > 0) ? 2'd1 : 2'd0;
        if (redir) begin
          ff = 1'b1;
          flush_left[i] = FC[i] - 1;
          stall_left[i] = 0;
        end else if (flush_left[i] > 0) begin
          ff = 1'b1;
          flush_left[i]--;
        end else if (stall_left[i] > 0) begin
          lh = 1'b1;
          stall_left[i]--;
        end else if (lu) begin
          lh = 1'b1;
          stall_left[i] = LL[i] - 1;
        end
      end
      e.ctrl[i] = {lh, lh, ff, lh, ff};
      e.st[i]   = st;
      e.sc[i]   = m_sc[i];
      e.fc[i]   = m_fc[i];
      if (lh) m_sc[i]++;
      if (ff) m_fc[i]++;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: compares whatever the DUTs present mid-cycle against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        for (int i = 0; i < N; i++) begin
          check("ctrl", i, mon_e.cyc,
                32'({pc_stall_w[i], if_id_stall_w[i], if_id_flush_w[i],
                     load_hazerd_w[i], flush_flag_w[i]}), 32'(mon_e.ctrl[i]));
          check("state_o", i, mon_e.cyc, 32'(state_w[i]), 32'(mon_e.st[i]));
`ifdef HAZARD_PERF_EN
          check("stall_cnt", i, mon_e.cyc, stall_cnt_w[i], mon_e.sc[i]);
          check("flush_cnt", i, mon_e.cyc, flush_cnt_w[i], mon_e.fc[i]);
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_opcode = '0; ex_rd_en = 1'b0; ex_rd_addr = '0; ex_redirect = 1'b0;
    for (int i = 0; i < N; i++) begin
      stall_left[i] = 0; flush_left[i] = 0; m_sc[i] = '0; m_fc[i] = '0;
    end

    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b0);
    idle(2);
    // lw x5 in EX, add x6,x5,x1 in ID; load leaves EX after one cycle
    step(1'b0, 5'd5, 5'd1, 1'b1, 1'b1, LW, 1'b1, 5'd5, 1'b0);
    idle(5);
    // lw x0, then rs2 match with rs2 unused: no stall
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, LW, 1'b1, 5'd0, 1'b0);
    step(1'b0, 5'd1, 5'd5, 1'b1, 1'b0, LW, 1'b1, 5'd5, 1'b0);
    idle(2);
    // redirect together with a load-use: flush wins
    step(1'b0, 5'd5, 5'd1, 1'b1, 1'b1, LW, 1'b1, 5'd5, 1'b1);
    idle(4);
    // back-to-back redirects restart the flush window
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b1);
    idle(4);
    // redirect arriving mid-stall
    step(1'b0, 5'd7, 5'd0, 1'b1, 1'b0, LW, 1'b1, 5'd7, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b1);
    idle(4);
    // reset pulse in the middle of a long stall
    step(1'b0, 5'd3, 5'd3, 1'b0, 1'b1, LW, 1'b1, 5'd3, 1'b0);
    idle(1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 7'd0, 1'b0, 5'd0, 1'b0);
    idle(4);

    for (int k = 0; k < 3000; k++) begin
      step(1'b0 || ($urandom_range(0, 99) < 2),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 1) == 1) ? LW : 7'($urandom),
           1'($urandom), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 8));
    end
    idle(3);

    repeat (4) @(posedge clk);
    check("scoreboard_drain", 0, cyc_n, 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
